// File: rtl/seq_detect_ctrl.sv
// ============================================================================
// seq_detect_ctrl : sequences a generator/detector pair for run_len bits and
//                   counts detector hits (saturating) and the first hit index
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_detect_ctrl #(
  parameter int LEN_W   = 8,
  parameter int MATCH_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [LEN_W-1:0]   run_len,
  input  logic               det_y,
  output logic               gen_en,
  output logic               det_clr,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [MATCH_W-1:0] match_cnt,
  output logic [LEN_W-1:0]   first_hit,
  output logic               first_hit_valid
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [MATCH_W-1:0] C_MATCH_MAX = {MATCH_W{1'b1}};

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   last_idx_q, last_idx_d;
  logic               en_d_q, en_d_d;
  logic               aborted_q, aborted_d;
  logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
  logic [LEN_W-1:0]   first_hit_q, first_hit_d;
  logic               first_hit_valid_q, first_hit_valid_d;
  logic               count_en;

  always_comb begin
    state_d           = state_q;
    len_d             = len_q;
    idx_d             = idx_q;
    last_idx_d        = last_idx_q;
    en_d_d            = (state_q == S_RUN);
    aborted_d         = 1'b0;
    match_cnt_d       = match_cnt_q;
    first_hit_d       = first_hit_q;
    first_hit_valid_d = first_hit_valid_q;

    // det_y answers the bit clocked one cycle earlier; only trust it while a run is live
    count_en = en_d_q && det_y && ((state_q == S_RUN) || (state_q == S_DRAIN));
    if (count_en) begin
      if (match_cnt_q != C_MATCH_MAX) begin
        match_cnt_d = match_cnt_q + MATCH_W'(1);
      end
      if (!first_hit_valid_q) begin
        first_hit_d       = last_idx_q;
        first_hit_valid_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          len_d             = run_len;
          idx_d             = '0;
          match_cnt_d       = '0;
          first_hit_d       = '0;
          first_hit_valid_d = 1'b0;
          state_d           = (run_len != '0) ? S_CLEAR : S_DONE;
        end
      end
      S_CLEAR: begin
        idx_d = '0;
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        last_idx_d = idx_q;
        idx_d      = idx_q + LEN_W'(1);
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (idx_q == len_q - LEN_W'(1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= S_IDLE;
      len_q             <= '0;
      idx_q             <= '0;
      last_idx_q        <= '0;
      en_d_q            <= 1'b0;
      aborted_q         <= 1'b0;
      match_cnt_q       <= '0;
      first_hit_q       <= '0;
      first_hit_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      len_q             <= len_d;
      idx_q             <= idx_d;
      last_idx_q        <= last_idx_d;
      en_d_q            <= en_d_d;
      aborted_q         <= aborted_d;
      match_cnt_q       <= match_cnt_d;
      first_hit_q       <= first_hit_d;
      first_hit_valid_q <= first_hit_valid_d;
    end
  end

  assign gen_en          = (state_q == S_RUN);
  assign det_clr         = (state_q == S_CLEAR);
  assign busy            = (state_q == S_CLEAR) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done            = (state_q == S_DONE);
  assign aborted         = aborted_q;
  assign match_cnt       = match_cnt_q;
  assign first_hit       = first_hit_q;
  assign first_hit_valid = first_hit_valid_q;

endmodule

`default_nettype wire

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 8, width of run_len and first_hit.
REQ-002 SHALL have parameter MATCH_W, default 4, width of match_cnt (saturating).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a detection run; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  terminate the current run.
REQ-007 SHALL have port run_len  input  LEN_W  number of bits to feed, latched on an accepted start.
REQ-008 SHALL have port det_y  input  1  detector match output, registered, valid the cycle after the completing bit is clocked.
REQ-009 SHALL have port gen_en  output  1  advance strobe to the sequence generator and detector (one bit per high cycle).
REQ-010 SHALL have port det_clr  output  1  one-cycle detector state clear.
REQ-011 SHALL have port busy  output  1  high in CLEAR, RUN and DRAIN.
REQ-012 SHALL have port done  output  1  one-cycle pulse on normal completion.
REQ-013 SHALL have port aborted  output  1  one-cycle pulse on abort completion.
REQ-014 SHALL have port match_cnt  output  MATCH_W  detections counted in the current or last run.
REQ-015 SHALL have port first_hit  output  LEN_W  0-based index of the bit whose clocking produced the first detection.
REQ-016 SHALL have port first_hit_valid  output  1  first_hit holds a valid index.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, RUN, DRAIN, DONE; all outputs decoded from registered state/counters.
REQ-018 IDLE: start=1, abort=0 -> latch run_len, clear match_cnt, first_hit, first_hit_valid; go CLEAR if run_len!=0, else go DONE.
REQ-019 CLEAR: det_clr=1 for exactly one cycle -> RUN.
REQ-020 RUN: gen_en=1 every cycle; bit index counts 0..run_len-1; after the cycle with index run_len-1 -> DRAIN.
REQ-021 DRAIN: gen_en=0 for one cycle, so det_y for the final bit is sampled -> DONE.
REQ-022 DONE: done=1 for one cycle -> IDLE.
REQ-023 det_y SHALL be counted only in cycles immediately following a gen_en=1 cycle (en_d=1); det_y at other times is ignored.
REQ-024 On a counted det_y, match_cnt SHALL increment, saturating at 2^MATCH_W-1 (no wrap).
REQ-025 On the first counted det_y of a run, first_hit SHALL take the index of the preceding gen_en bit and first_hit_valid SHALL go to 1; later hits SHALL not change it.
REQ-026 start while not in IDLE SHALL be ignored (not queued).
REQ-027 abort=1 in CLEAR, RUN or DRAIN SHALL go to IDLE next edge: gen_en=0 from that edge, aborted=1 for one cycle, done not asserted; a det_y sampled on the abort edge is still counted; match_cnt, first_hit and first_hit_valid are held.
REQ-028 abort=1 in IDLE or DONE SHALL have no effect; start and abort together in IDLE SHALL leave the block in IDLE.
REQ-029 match_cnt, first_hit and first_hit_valid SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-030 reset=1 at a rising edge SHALL force IDLE and set gen_en, det_clr, busy, done, aborted, match_cnt, first_hit, first_hit_valid and the internal en_d to 0, in any state including mid-run.
REQ-031 reset SHALL take priority over start and abort.

Verification
REQ-032 reset, then start with run_len=8, det_y=0 -> det_clr high for 1 cycle after the start edge; gen_en high exactly 8 cycles; busy high 10 cycles; done pulses 11 cycles after the start edge; match_cnt=0; first_hit_valid=0.
REQ-033 run_len=8, det_y high one cycle after bits 3 and 6 -> match_cnt=2, first_hit=3, first_hit_valid=1 at done.
REQ-034 run_len=0 -> done one cycle after the start edge; gen_en, det_clr and busy never high; match_cnt=0.
REQ-035 run_len=40, det_y held 1 -> match_cnt saturates at 15; first_hit=0; done after 43 cycles.
REQ-036 abort after 4 gen_en bits -> gen_en low next edge; aborted pulses once; no done; match_cnt keeps the partial count; start pulses during the run are ignored.
REQ-037 reset asserted mid-RUN -> all outputs 0 next edge; a new start then runs normally.
